sample_sequencer: RTL and testbench
===================================

Name: sample_sequencer

Overview:
- Controller for the receiver's multi-antenna sampling path.
- A rate tick (internal divider, CLK_FREQ/ROUND_FREQ) starts a sampling round.
- Each round walks all NUM_CH antenna channels in order: drive the analog mux, wait a settle time, pulse the ADC start, wait for done, then forward the tagged sample downstream.
- Sits between the ADC/mux interface and the per-channel detection DSP.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- ROUND_FREQ, 40_000, round start rate in Hz; tick period = floor(CLK_FREQ/ROUND_FREQ) cycles.
- NUM_CH, 3, number of antenna channels (>=1).
- SETTLE_CYC, 8, mux settle cycles before ADC start (>=1).
- TIMEOUT_CYC, 256, WAIT cycles allowed before a conversion is abandoned (>=2).
- ADC_W, 12, ADC sample width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- run_i  in  1  level; 1 = start rounds on ticks.
- adc_done_i  in  1  one-cycle pulse from ADC; conversion complete.
- adc_data_i  in  ADC_W  ADC result; valid with adc_done_i.
- mux_sel_o  out  CH_W=max(1,$clog2(NUM_CH))  analog mux select.
- adc_start_o  out  1  one-cycle conversion start pulse.
- sample_valid_o  out  1  one-cycle pulse; sample outputs valid.
- sample_data_o  out  ADC_W  captured sample (0 on timeout).
- sample_ch_o  out  CH_W  channel of the sample.
- sample_err_o  out  1  qualifies sample_valid_o; 1 = timeout, data invalid.
- round_done_o  out  1  one-cycle pulse after the last channel's sample.
- overrun_o  out  1  one-cycle pulse when a tick is dropped because a round is active.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, channel 0, counters 0, divider count 0.
- Tick divider:
  - Free-runs from reset, independent of run_i.
  - Emits a registered one-cycle tick every floor(CLK_FREQ/ROUND_FREQ) cycles; the first tick is on that cycle count after reset release.
- State machine: IDLE, SETTLE, CONVERT, WAIT, EMIT.
- IDLE:
  - On tick with run_i=1 at cycle T: ch=0, mux_sel_o=0, settle count cleared; enter SETTLE at T+1.
  - On tick with run_i=0: stay in IDLE; no overrun.
- SETTLE:
  - mux_sel_o holds ch.
  - Stays exactly SETTLE_CYC cycles, then enters CONVERT.
- CONVERT:
  - Single cycle; adc_start_o=1.
  - Next state WAIT; timeout count cleared.
- WAIT:
  - adc_done_i=1: latch adc_data_i, err=0, go to EMIT.
  - Else, if this is the TIMEOUT_CYC-th WAIT cycle: data=0, err=1, go to EMIT.
  - done and timeout on the same cycle: done wins.
- EMIT:
  - Single cycle: sample_valid_o=1, sample_ch_o=ch, sample_data_o/sample_err_o registered.
  - If ch==NUM_CH-1: round_done_o=1 in the same cycle, then IDLE.
  - Else: ch+1, mux_sel_o updates, then SETTLE.
- Timing example: with tick at T, first adc_start_o is at T+SETTLE_CYC+1. A done at cycle D gives sample_valid_o at D+1.
- adc_done_i outside WAIT is ignored; no effect on state or outputs.
- Tick while busy_o=1: overrun_o pulses the same cycle, tick dropped, round continues unchanged.
- run_i deasserted mid-round: the current round completes fully; no further rounds start.
- Channel counter never exceeds NUM_CH-1; NUM_CH=1 gives SETTLE→CONVERT→WAIT→EMIT→IDLE per tick.
- Width rules:
  - Settle counter: $clog2(SETTLE_CYC+1) bits.
  - Timeout counter: $clog2(TIMEOUT_CYC+1) bits.
  - Divider: $clog2(period) bits, minimum 1.
- Reset asserted mid-operation: immediate return to reset values, including any output pulse in flight.

Decomposition:
- Package sample_seq_pkg:
  - state enum seq_state_t {IDLE, SETTLE, CONVERT, WAIT, EMIT}.
  - Helper function computing tick period from CLK_FREQ/ROUND_FREQ.
- Sub-module tick_divider (CLK_FREQ, EN_FREQ → registered one-cycle tick). Instantiated once; the FSM is the top.

Test Plan:
- Bench config: CLK_FREQ=1000, ROUND_FREQ=10, NUM_CH=3, SETTLE_CYC=4, TIMEOUT_CYC=16, ADC model answers 3 cycles after start with data 0x100+ch.
- Nominal round, run_i=1: first tick at cycle 100 → adc_start_o at 105, 3 starts total, valids with ch 0/1/2 and data 0x100/0x101/0x102, err=0. round_done_o coincides with the ch2 valid, then busy_o=0.
- ADC silent on ch1 → valid ch1, data 0, err=1, exactly 16 WAIT cycles after start+1. ch2 still sampled normally; round_done_o asserted.
- Timeout during a long round: with TIMEOUT_CYC=16, one timeout on each channel lasts ~3×(4+1+16+1) = 66 cycles, which is shorter than the 100-cycle tick period, so no overrun. Separately, set ROUND_FREQ=20 (period 50) and force ADC timeouts on all channels → the tick at cycle 100 is dropped with overrun_o=1, and the in-progress round still completes 3 valids.
- Drop run_i in the middle of the ch1 SETTLE → round finishes with all 3 valids; the next tick at 200 starts nothing, and overrun_o=0.
- Spurious adc_done_i in IDLE/SETTLE/CONVERT → no valid. Done and the timeout-th cycle together → err=0 with ADC data.
- Assert rst during WAIT → all outputs 0 next edge; after release the first tick comes after a full 100 cycles.

Source files
------------

// File: rtl/sample_seq_pkg.sv
// Shared types and helpers for the antenna sampling sequencer.
// Holds the FSM state encoding and the rate-tick period calculation.
package sample_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        CONVERT = 3'd2,
        WAIT    = 3'd3,
        EMIT    = 3'd4
    } seq_state_t;

    // Tick period in clock cycles; clamped so a too-fast rate still ticks every cycle.
    function automatic int tick_period(input int clk_freq, input int en_freq);
        int p;
        p = clk_freq / en_freq;
        return (p < 1) ? 1 : p;
    endfunction

    function automatic int width_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/sample_sequencer_tick_divider.sv
// Free-running rate divider: one registered single-cycle tick every
// floor(CLK_FREQ/EN_FREQ) cycles, first tick that many cycles after reset.
module tick_divider
    import sample_seq_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int EN_FREQ  = 40_000
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int PERIOD = tick_period(CLK_FREQ, EN_FREQ);
    localparam int CNT_W  = width_min1(PERIOD);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CNT_W'(PERIOD - 1)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/sample_sequencer.sv
// Multi-antenna sampling controller: on each rate tick walks every channel
// through mux settle, ADC start, wait-for-done/timeout and tagged sample emit.
module sample_sequencer
    import sample_seq_pkg::*;
#(
    parameter  int CLK_FREQ    = 100_000_000,
    parameter  int ROUND_FREQ  = 40_000,
    parameter  int NUM_CH      = 3,
    parameter  int SETTLE_CYC  = 8,
    parameter  int TIMEOUT_CYC = 256,
    parameter  int ADC_W       = 12,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             adc_done_i,
    input  logic [ADC_W-1:0] adc_data_i,
    output logic [CH_W-1:0]  mux_sel_o,
    output logic             adc_start_o,
    output logic             sample_valid_o,
    output logic [ADC_W-1:0] sample_data_o,
    output logic [CH_W-1:0]  sample_ch_o,
    output logic             sample_err_o,
    output logic             round_done_o,
    output logic             overrun_o,
    output logic             busy_o
);

    localparam int ST_W = $clog2(SETTLE_CYC + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic             w_tick;
    logic             w_last_ch;
    seq_state_t       r_state;
    logic [CH_W-1:0]  r_ch;
    logic [CH_W-1:0]  r_mux;
    logic [ST_W-1:0]  r_settle;
    logic [TO_W-1:0]  r_to;
    logic             r_start;
    logic             r_valid;
    logic [ADC_W-1:0] r_data;
    logic [CH_W-1:0]  r_sch;
    logic             r_err;
    logic             r_rdone;

    tick_divider #(
        .CLK_FREQ (CLK_FREQ),
        .EN_FREQ  (ROUND_FREQ)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    assign w_last_ch = (r_ch == CH_W'(NUM_CH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ch     <= '0;
            r_mux    <= '0;
            r_settle <= '0;
            r_to     <= '0;
            r_start  <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_sch    <= '0;
            r_err    <= 1'b0;
            r_rdone  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_valid <= 1'b0;
            r_rdone <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_tick && run_i) begin
                        r_ch     <= '0;
                        r_mux    <= '0;
                        r_settle <= '0;
                        r_state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Start pulse is registered so it lands exactly in the CONVERT cycle.
                    if (r_settle == ST_W'(SETTLE_CYC - 1)) begin
                        r_start <= 1'b1;
                        r_state <= CONVERT;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                CONVERT: begin
                    r_to    <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Done is checked first so a late-but-valid answer beats the timeout.
                    if (adc_done_i) begin
                        r_data  <= adc_data_i;
                        r_err   <= 1'b0;
                        r_valid <= 1'b1;
                        r_sch   <= r_ch;
                        r_rdone <= w_last_ch;
                        r_state <= EMIT;
                    end else if (r_to == TO_W'(TIMEOUT_CYC - 1)) begin
                        r_data  <= '0;
                        r_err   <= 1'b1;
                        r_valid <= 1'b1;
                        r_sch   <= r_ch;
                        r_rdone <= w_last_ch;
                        r_state <= EMIT;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end
                EMIT: begin
                    if (w_last_ch) begin
                        r_state <= IDLE;
                    end else begin
                        r_ch     <= r_ch + 1'b1;
                        r_mux    <= r_ch + 1'b1;
                        r_settle <= '0;
                        r_state  <= SETTLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mux_sel_o      = r_mux;
    assign adc_start_o    = r_start;
    assign sample_valid_o = r_valid;
    assign sample_data_o  = r_data;
    assign sample_ch_o    = r_sch;
    assign sample_err_o   = r_err;
    assign round_done_o   = r_rdone;
    assign busy_o         = (r_state != IDLE);
    // A tick landing on an active round is dropped and flagged in the same cycle.
    assign overrun_o      = w_tick && (r_state != IDLE);

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench: nominal rounds, timeouts, overrun, run drop, spurious done
// and mid-round reset, with cycle numbers counted from reset release.
module tb_sample_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1, rst2 = 1'b1;
    logic        run = 1'b1, run2 = 1'b1;
    logic        mdl_done = 1'b0, spur = 1'b0;
    logic        adc_done;
    logic [11:0] adc_data = '0;
    logic        zero_done = 1'b0;
    logic [11:0] zero_data = '0;

    logic [1:0]  mux_sel, sch;
    logic [11:0] sdata;
    logic        start, valid, serr, rdone, ovr, busy;
    logic [1:0]  mux_sel2, sch2;
    logic [11:0] sdata2;
    logic        start2, valid2, serr2, rdone2, ovr2, busy2;

    assign adc_done = mdl_done | spur;

    sample_sequencer #(
        .CLK_FREQ(1000), .ROUND_FREQ(10), .NUM_CH(3),
        .SETTLE_CYC(4), .TIMEOUT_CYC(16), .ADC_W(12)
    ) dut (
        .clk(clk), .rst(rst), .run_i(run), .adc_done_i(adc_done), .adc_data_i(adc_data),
        .mux_sel_o(mux_sel), .adc_start_o(start), .sample_valid_o(valid),
        .sample_data_o(sdata), .sample_ch_o(sch), .sample_err_o(serr),
        .round_done_o(rdone), .overrun_o(ovr), .busy_o(busy)
    );

    // Faster rounds with a silent ADC: every channel times out and rounds overlap ticks.
    sample_sequencer #(
        .CLK_FREQ(1000), .ROUND_FREQ(20), .NUM_CH(3),
        .SETTLE_CYC(4), .TIMEOUT_CYC(16), .ADC_W(12)
    ) dut2 (
        .clk(clk), .rst(rst2), .run_i(run2), .adc_done_i(zero_done), .adc_data_i(zero_data),
        .mux_sel_o(mux_sel2), .adc_start_o(start2), .sample_valid_o(valid2),
        .sample_data_o(sdata2), .sample_ch_o(sch2), .sample_err_o(serr2),
        .round_done_o(rdone2), .overrun_o(ovr2), .busy_o(busy2)
    );

    always #5 clk = ~clk;

    int cyc = 0, cyc2 = 0, cd = 0;
    int n_chk = 0, n_err = 0;
    int dly [4] = '{3, 3, 3, 3};
    logic [3:0] silent = '0;

    int st_q[$], vc_q[$], vch_q[$], vd_q[$], ve_q[$], rd_q[$], ov_q[$];
    int v2c_q[$], v2ch_q[$], v2d_q[$], v2e_q[$], rd2_q[$], ov2_q[$];

    always @(posedge clk) begin
        cyc  = rst  ? 0 : cyc + 1;
        cyc2 = rst2 ? 0 : cyc2 + 1;
    end

    // ADC model: answers dly[ch] cycles after the start pulse with 0x100+ch.
    always @(negedge clk) begin
        mdl_done = 1'b0;
        if (rst) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    mdl_done = 1'b1;
                    adc_data = 12'h100 + 12'(mux_sel);
                end
            end
            if (start && !silent[mux_sel]) cd = dly[mux_sel];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (start) st_q.push_back(cyc);
            if (valid) begin
                vc_q.push_back(cyc); vch_q.push_back(int'(sch));
                vd_q.push_back(int'(sdata)); ve_q.push_back(int'(serr));
            end
            if (rdone) rd_q.push_back(cyc);
            if (ovr) ov_q.push_back(cyc);
        end
        if (!rst2) begin
            if (valid2) begin
                v2c_q.push_back(cyc2); v2ch_q.push_back(int'(sch2));
                v2d_q.push_back(int'(sdata2)); v2e_q.push_back(int'(serr2));
            end
            if (rdone2) rd2_q.push_back(cyc2);
            if (ovr2) ov2_q.push_back(cyc2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic goto(input int n);
        int guard = 0;
        while (cyc < n && guard < 5000) begin
            @(negedge clk); #1;
            guard++;
        end
        if (guard >= 5000) chk("goto_timeout", 32'(cyc), 32'(n));
    endtask

    task automatic clr();
        st_q.delete(); vc_q.delete(); vch_q.delete(); vd_q.delete();
        ve_q.delete(); rd_q.delete(); ov_q.delete();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".mux"},   32'(mux_sel), 0);
        chk({tag, ".start"}, 32'(start),   0);
        chk({tag, ".valid"}, 32'(valid),   0);
        chk({tag, ".data"},  32'(sdata),   0);
        chk({tag, ".ch"},    32'(sch),     0);
        chk({tag, ".err"},   32'(serr),    0);
        chk({tag, ".rdone"}, 32'(rdone),   0);
        chk({tag, ".ovr"},   32'(ovr),     0);
        chk({tag, ".busy"},  32'(busy),    0);
    endtask

    // Expected start cycles, valid cycles, data per channel, err bitmask, round-done cycle.
    task automatic chk_round(input string tag,
                             input int s0, input int s1, input int s2,
                             input int c0, input int c1, input int c2,
                             input int d0, input int d1, input int d2,
                             input int emask, input int rdc);
        int s[3], c[3], d[3];
        s = '{s0, s1, s2}; c = '{c0, c1, c2}; d = '{d0, d1, d2};
        chk({tag, ".nstart"}, 32'(st_q.size()), 3);
        chk({tag, ".nvalid"}, 32'(vc_q.size()), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.start%0d", tag, i), 32'((i < st_q.size()) ? st_q[i] : -1), 32'(s[i]));
            chk($sformatf("%s.vcyc%0d",  tag, i), 32'((i < vc_q.size()) ? vc_q[i] : -1), 32'(c[i]));
            chk($sformatf("%s.vch%0d",   tag, i), 32'((i < vch_q.size()) ? vch_q[i] : -1), 32'(i));
            chk($sformatf("%s.vdat%0d",  tag, i), 32'((i < vd_q.size()) ? vd_q[i] : -1), 32'(d[i]));
            chk($sformatf("%s.verr%0d",  tag, i), 32'((i < ve_q.size()) ? ve_q[i] : -1), 32'((emask >> i) & 1));
        end
        chk({tag, ".nrdone"}, 32'(rd_q.size()), 1);
        chk({tag, ".rdcyc"},  32'((rd_q.size() > 0) ? rd_q[0] : -1), 32'(rdc));
        chk({tag, ".novr"},   32'(ov_q.size()), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk_idle("rst");
        rst = 1'b0; rst2 = 1'b0;

        // First tick at cycle 100 after release.
        goto(100);
        chk("tick.busy99", 32'(busy), 0);
        goto(101);
        chk("tick.busy101", 32'(busy), 1);
        goto(130);
        chk_round("nom", 105, 114, 123, 109, 118, 127, 'h100, 'h101, 'h102, 0, 127);
        chk("nom.busy_end", 32'(busy), 0);

        // Overlapping rounds on the 50-cycle instance: all timeouts, tick 100 dropped.
        chk("ovr.n", 32'(ov2_q.size()), 1);
        chk("ovr.cyc", 32'((ov2_q.size() > 0) ? ov2_q[0] : -1), 100);
        chk("ovr.nvalid", 32'(v2c_q.size()), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ovr.vcyc%0d", i), 32'((i < v2c_q.size()) ? v2c_q[i] : -1), 32'(72 + 22 * i));
            chk($sformatf("ovr.vch%0d", i),  32'((i < v2ch_q.size()) ? v2ch_q[i] : -1), 32'(i));
            chk($sformatf("ovr.vdat%0d", i), 32'((i < v2d_q.size()) ? v2d_q[i] : -1), 0);
            chk($sformatf("ovr.verr%0d", i), 32'((i < v2e_q.size()) ? v2e_q[i] : -1), 1);
        end
        chk("ovr.rdcyc", 32'((rd2_q.size() > 0) ? rd2_q[0] : -1), 116);

        // Silent ADC on ch1: timeout after 16 WAIT cycles, ch2 unaffected.
        clr();
        silent = 4'b0010;
        goto(250);
        chk_round("tmo", 205, 214, 236, 209, 231, 240, 'h100, 0, 'h102, 2, 240);

        // Spurious done in IDLE/SETTLE/CONVERT, done on the timeout cycle, run dropped mid-round.
        clr();
        silent = '0;
        dly[1] = 16;
        spur = 1'b1; goto(251); spur = 1'b0;
        goto(302); spur = 1'b1; goto(303); spur = 1'b0;
        goto(305); spur = 1'b1; goto(306); spur = 1'b0;
        goto(311); run = 1'b0;
        goto(312); spur = 1'b1; goto(313); spur = 1'b0;
        goto(420);
        chk_round("drop", 305, 314, 336, 309, 331, 340, 'h100, 'h101, 'h102, 0, 340);
        chk("drop.busy", 32'(busy), 0);

        // Reset while waiting on ch1; pulses in flight are cancelled.
        clr();
        run = 1'b1;
        dly[1] = 3;
        goto(516);
        chk("rstw.mux_pre", 32'(mux_sel), 1);
        chk("rstw.busy_pre", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk_idle("rstw");
        repeat (3) @(negedge clk);
        #1;
        chk_idle("rstw_hold");
        chk("rstw.nvalid", 32'(vc_q.size()), 1);
        clr();
        rst = 1'b0;
        goto(100);
        chk("rel.busy100", 32'(busy), 0);
        goto(101);
        chk("rel.busy101", 32'(busy), 1);
        goto(110);
        chk("rel.nstart", 32'(st_q.size()), 1);
        chk("rel.start", 32'((st_q.size() > 0) ? st_q[0] : -1), 105);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
